// File: rtl/image_scale_engine.sv
// Power-of-two image scaler: NN / pixel-replicate / decimate / block-average from source RAM to frame buffer.
// Latency: per output pixel RD_LAT+3 (NN/DC), 4^s*(RD_LAT+1)+2 (BA); per source pixel RD_LAT+2+4^s (PR).
// Backpressure: none; read data is taken RD_LAT cycles after rd_en, writes are fire-and-forget.
//
// Ports: CLK/RESET (async active-high); enable/busy/done/error control handshake;
//        ALGORITHM, SCALE_LOG2, SRC_WIDTH, SRC_HEIGHT job config (latched in S_SETUP);
//        R_ADDR/rd_en/PIXEL_IN source read port; W_ADDR/wren_out/PIXEL_OUT destination write port.
// Optional macro IMAGE_SCALE_ROUND_EN: block average rounds half up instead of truncating.
module image_scale_engine #(
    parameter int PIX_W  = 8,
    parameter int SRC_AW = 15,
    parameter int DST_AW = 17,
    parameter int XW     = 11,
    parameter int YW     = 10,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              enable,
    input  logic [1:0]        ALGORITHM,
    input  logic [1:0]        SCALE_LOG2,
    input  logic [XW-1:0]     SRC_WIDTH,
    input  logic [YW-1:0]     SRC_HEIGHT,
    input  logic [PIX_W-1:0]  PIXEL_IN,
    output logic [SRC_AW-1:0] R_ADDR,
    output logic              rd_en,
    output logic [PIX_W-1:0]  PIXEL_OUT,
    output logic [DST_AW-1:0] W_ADDR,
    output logic              wren_out,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int PW   = XW + YW + 4;          // wide enough for any coordinate product
    localparam int ACCW = PIX_W + 4;            // 16 samples of PIX_W bits
    localparam int WCW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [1:0] ALG_NN = 2'b00;
    localparam logic [1:0] ALG_PR = 2'b01;
    localparam logic [1:0] ALG_DC = 2'b10;
    localparam logic [1:0] ALG_BA = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_READ, S_WAIT, S_WRITE, S_UPDATE, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        alg_q, alg_d, s_q, s_d;
    logic [XW-1:0]     src_w_q, src_w_d;
    logic [YW-1:0]     src_h_q, src_h_d;
    logic [XW+1:0]     out_w_q, out_w_d, cur_x_q, cur_x_d;
    logic [YW+1:0]     out_h_q, out_h_d, cur_y_q, cur_y_d;
    logic [1:0]        sub_x_q, sub_x_d, sub_y_q, sub_y_d;
    logic [WCW-1:0]    wait_q, wait_d;
    logic [ACCW-1:0]   acc_q, acc_d;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic              err_q, err_d;

    // Setup-time geometry check, evaluated straight from the inputs.
    logic [XW+1:0]     set_w;
    logic [YW+1:0]     set_h;
    logic [PW-1:0]     area;
    logic              set_err;

    always_comb begin
        // ALGORITHM[1] separates the shrinking modes (DC/BA) from the growing ones (NN/PR).
        set_w   = ALGORITHM[1] ? ({2'b00, SRC_WIDTH} >> SCALE_LOG2) : ({2'b00, SRC_WIDTH} << SCALE_LOG2);
        set_h   = ALGORITHM[1] ? ({2'b00, SRC_HEIGHT} >> SCALE_LOG2) : ({2'b00, SRC_HEIGHT} << SCALE_LOG2);
        area    = PW'(set_w) * PW'(set_h);
        // area > 2^DST_AW  <=>  (area-1) has a bit at or above DST_AW (area is non-zero when it matters)
        set_err = (SCALE_LOG2 == 2'd3) || (SRC_WIDTH == '0) || (SRC_HEIGHT == '0) ||
                  (set_w == '0) || (set_h == '0) || (((area - PW'(1)) >> DST_AW) != '0);
    end

    // Walk geometry: PR walks the source raster, the other modes walk the output raster.
    logic [XW+1:0] walk_w;
    logic [YW+1:0] walk_h;
    logic [1:0]    bmax, sub_x_nx, sub_y_nx;
    logic          blk_last;

    always_comb begin
        walk_w   = (alg_q == ALG_PR) ? {2'b00, src_w_q} : out_w_q;
        walk_h   = (alg_q == ALG_PR) ? {2'b00, src_h_q} : out_h_q;
        bmax     = (s_q == 2'd0) ? 2'd0 : ((s_q == 2'd1) ? 2'd1 : 2'd3);
        blk_last = (sub_x_q == bmax) && (sub_y_q == bmax);
        if (sub_x_q == bmax) begin
            sub_x_nx = 2'd0;
            sub_y_nx = sub_y_q + 2'd1;
        end else begin
            sub_x_nx = sub_x_q + 2'd1;
            sub_y_nx = sub_y_q;
        end
    end

    // Source / destination coordinates and full-width linear addresses.
    logic [PW-1:0] cx, cy, rx, ry, wx, wy, rd_full, wr_full;

    always_comb begin
        cx = PW'(cur_x_q);
        cy = PW'(cur_y_q);
        rx = cx;
        ry = cy;
        wx = cx;
        wy = cy;
        case (alg_q)
            ALG_NN: begin
                rx = cx >> s_q;
                ry = cy >> s_q;
            end
            ALG_DC: begin
                rx = cx << s_q;
                ry = cy << s_q;
            end
            ALG_BA: begin
                rx = (cx << s_q) + PW'(sub_x_q);
                ry = (cy << s_q) + PW'(sub_y_q);
            end
            default: begin  // PR: one read, then the whole replicated block
                wx = (cx << s_q) + PW'(sub_x_q);
                wy = (cy << s_q) + PW'(sub_y_q);
            end
        endcase
        rd_full = ry * PW'(src_w_q) + rx;
        wr_full = wy * PW'(out_w_q) + wx;
    end

    // Block average: divide by 4^s with a shift by 2s.
    logic [2:0]       sh2;
    logic [ACCW-1:0]  rnd, acc_rnd;
    logic [PIX_W-1:0] ba_val;

    always_comb begin
        sh2 = {s_q, 1'b0};
`ifdef IMAGE_SCALE_ROUND_EN
        rnd = (s_q == 2'd0) ? '0 : (ACCW'(1) << (sh2 - 3'd1));
`else
        rnd = '0;
`endif
        acc_rnd = acc_q + rnd;
        ba_val  = PIX_W'(acc_rnd >> sh2);
    end

    assign rd_en     = (state_q == S_READ);
    assign wren_out  = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign error     = err_q;
    assign R_ADDR    = rd_en ? SRC_AW'(rd_full) : '0;
    assign W_ADDR    = wren_out ? DST_AW'(wr_full) : '0;
    assign PIXEL_OUT = wren_out ? ((alg_q == ALG_BA) ? ba_val : pix_q) : '0;

    always_comb begin
        state_d = state_q;
        alg_d   = alg_q;
        s_d     = s_q;
        src_w_d = src_w_q;
        src_h_d = src_h_q;
        out_w_d = out_w_q;
        out_h_d = out_h_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        sub_x_d = sub_x_q;
        sub_y_d = sub_y_q;
        wait_d  = wait_q;
        acc_d   = acc_q;
        pix_d   = pix_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_SETUP;
            S_SETUP: begin
                alg_d   = ALGORITHM;
                s_d     = SCALE_LOG2;
                src_w_d = SRC_WIDTH;
                src_h_d = SRC_HEIGHT;
                out_w_d = set_w;
                out_h_d = set_h;
                cur_x_d = '0;
                cur_y_d = '0;
                sub_x_d = 2'd0;
                sub_y_d = 2'd0;
                acc_d   = '0;
                err_d   = set_err;
                state_d = set_err ? S_DONE : S_READ;
            end
            S_READ: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == WCW'(RD_LAT - 1)) begin
                    if (alg_q == ALG_BA) begin
                        acc_d = acc_q + ACCW'(PIXEL_IN);
                        if (blk_last) begin
                            sub_x_d = 2'd0;
                            sub_y_d = 2'd0;
                            state_d = S_WRITE;
                        end else begin
                            sub_x_d = sub_x_nx;
                            sub_y_d = sub_y_nx;
                            state_d = S_READ;
                        end
                    end else begin
                        pix_d   = PIXEL_IN;
                        state_d = S_WRITE;
                    end
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            S_WRITE: begin
                if (alg_q == ALG_BA) acc_d = '0;
                if ((alg_q == ALG_PR) && !blk_last) begin
                    sub_x_d = sub_x_nx;
                    sub_y_d = sub_y_nx;
                end else begin
                    sub_x_d = 2'd0;
                    sub_y_d = 2'd0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_d = S_READ;
                if (cur_x_q == walk_w - (XW+2)'(1)) begin
                    cur_x_d = '0;
                    if (cur_y_q == walk_h - (YW+2)'(1)) state_d = S_DONE;
                    else cur_y_d = cur_y_q + (YW+2)'(1);
                end else begin
                    cur_x_d = cur_x_q + (XW+2)'(1);
                end
            end
            S_DONE: begin
                if (!enable) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            alg_q   <= '0;
            s_q     <= '0;
            src_w_q <= '0;
            src_h_q <= '0;
            out_w_q <= '0;
            out_h_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            sub_x_q <= '0;
            sub_y_q <= '0;
            wait_q  <= '0;
            acc_q   <= '0;
            pix_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            alg_q   <= alg_d;
            s_q     <= s_d;
            src_w_q <= src_w_d;
            src_h_q <= src_h_d;
            out_w_q <= out_w_d;
            out_h_q <= out_h_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            sub_x_q <= sub_x_d;
            sub_y_q <= sub_y_d;
            wait_q  <= wait_d;
            acc_q   <= acc_d;
            pix_q   <= pix_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_image_scale_engine.sv
// Scoreboard bench for image_scale_engine: a reference model expands each job into expected
// read addresses and (address, data) writes; a negedge monitor pops and compares them.
module tb_image_scale_engine;
    localparam int PIX_W  = 8;
    localparam int SRC_AW = 15;
    localparam int DST_AW = 17;
    localparam int XW     = 11;
    localparam int YW     = 10;
    localparam int RD_LAT = 2;

    logic              CLK = 1'b0;
    logic              RESET;
    logic              enable;
    logic [1:0]        ALGORITHM;
    logic [1:0]        SCALE_LOG2;
    logic [XW-1:0]     SRC_WIDTH;
    logic [YW-1:0]     SRC_HEIGHT;
    logic [PIX_W-1:0]  PIXEL_IN;
    logic [SRC_AW-1:0] R_ADDR;
    logic              rd_en;
    logic [PIX_W-1:0]  PIXEL_OUT;
    logic [DST_AW-1:0] W_ADDR;
    logic              wren_out;
    logic              busy;
    logic              done;
    logic              error;

    image_scale_engine #(
        .PIX_W(PIX_W), .SRC_AW(SRC_AW), .DST_AW(DST_AW),
        .XW(XW), .YW(YW), .RD_LAT(RD_LAT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .enable(enable),
        .ALGORITHM(ALGORITHM), .SCALE_LOG2(SCALE_LOG2),
        .SRC_WIDTH(SRC_WIDTH), .SRC_HEIGHT(SRC_HEIGHT),
        .PIXEL_IN(PIXEL_IN), .R_ADDR(R_ADDR), .rd_en(rd_en),
        .PIXEL_OUT(PIXEL_OUT), .W_ADDR(W_ADDR), .wren_out(wren_out),
        .busy(busy), .done(done), .error(error)
    );

    always #5 CLK = ~CLK;

    // Source RAM with RD_LAT-cycle read pipeline.
    logic [PIX_W-1:0] mem  [0:(1<<SRC_AW)-1];
    logic [PIX_W-1:0] pipe [0:RD_LAT-1];
    always @(posedge CLK) begin
        if (rd_en) pipe[0] <= mem[R_ADDR];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign PIXEL_IN = pipe[RD_LAT-1];

    int cyc_ctr = 0;
    always @(posedge CLK) cyc_ctr <= cyc_ctr + 1;

    int total = 0;
    int bad   = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    bit mon_on = 1'b0;
    int exp_ra[$];
    int exp_wa[$];
    int exp_wd[$];

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: every read/write the DUT presents is matched against the scoreboard.
    always @(negedge CLK) begin
        if (mon_on && !RESET) begin
            if (rd_en && wren_out) chk("rd_wr_exclusive", 1, 0);
            if (rd_en) begin
                rd_cnt++;
                if (exp_ra.size() == 0) chk("unexpected_read", longint'(R_ADDR), -1);
                else chk("r_addr", longint'(R_ADDR), longint'(exp_ra.pop_front()));
            end
            if (wren_out) begin
                wr_cnt++;
                if (exp_wa.size() == 0) chk("unexpected_write", longint'(W_ADDR), -1);
                else begin
                    chk("w_addr", longint'(W_ADDR), longint'(exp_wa.pop_front()));
                    chk("w_data", longint'(PIXEL_OUT), longint'(exp_wd.pop_front()));
                end
            end
        end
    end

    // Reference model: expands a job into expected reads/writes and the job length in cycles.
    task automatic build(input int alg, input int s, input int w, input int h,
                         output bit err, output int cyc);
        int ow, oh, n, ra, sum, amask;
        amask = (1 << SRC_AW) - 1;
        if (alg < 2) begin ow = w << s; oh = h << s; end
        else         begin ow = w >> s; oh = h >> s; end
        err = (s == 3) || (w == 0) || (h == 0) || (ow == 0) || (oh == 0) ||
              (longint'(ow) * longint'(oh) > (longint'(1) << DST_AW));
        cyc = 1;
        n = 1 << s;
        if (!err) begin
            if (alg == 1) begin
                for (int sy = 0; sy < h; sy++)
                    for (int sx = 0; sx < w; sx++) begin
                        ra = (sy * w + sx) & amask;
                        exp_ra.push_back(ra);
                        for (int by = 0; by < n; by++)
                            for (int bx = 0; bx < n; bx++) begin
                                exp_wa.push_back((sy * n + by) * ow + sx * n + bx);
                                exp_wd.push_back(int'(mem[ra]));
                            end
                        cyc += 1 + RD_LAT + n * n + 1;
                    end
            end else begin
                for (int oy = 0; oy < oh; oy++)
                    for (int ox = 0; ox < ow; ox++) begin
                        exp_wa.push_back(oy * ow + ox);
                        if (alg == 3) begin
                            sum = 0;
                            for (int by = 0; by < n; by++)
                                for (int bx = 0; bx < n; bx++) begin
                                    ra = ((oy * n + by) * w + ox * n + bx) & amask;
                                    exp_ra.push_back(ra);
                                    sum += int'(mem[ra]);
                                end
`ifdef IMAGE_SCALE_ROUND_EN
                            exp_wd.push_back((sum + (n * n) / 2) / (n * n));
`else
                            exp_wd.push_back(sum / (n * n));
`endif
                            cyc += n * n * (RD_LAT + 1) + 2;
                        end else begin
                            if (alg == 0) ra = ((oy / n) * w + ox / n) & amask;
                            else          ra = ((oy * n) * w + ox * n) & amask;
                            exp_ra.push_back(ra);
                            exp_wd.push_back(int'(mem[ra]));
                            cyc += RD_LAT + 3;
                        end
                    end
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        mon_on = 1'b0;
        RESET  = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        exp_ra.delete();
        exp_wa.delete();
        exp_wd.delete();
        mon_on = 1'b1;
    endtask

    task automatic run_job(input int alg, input int s, input int w, input int h);
        bit err, seen;
        int cyc_exp, nr, nw, t_en, t0, t1;
        build(alg, s, w, h, err, cyc_exp);
        nr = exp_ra.size();
        nw = exp_wa.size();
        rd_cnt = 0;
        wr_cnt = 0;
        @(negedge CLK);
        ALGORITHM  = 2'(alg);
        SCALE_LOG2 = 2'(s);
        SRC_WIDTH  = XW'(w);
        SRC_HEIGHT = YW'(h);
        enable     = 1'b1;
        t_en = cyc_ctr;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge CLK);
            seen = busy;
        end
        chk("setup_seen", longint'(seen), 1);
        t0 = cyc_ctr;
        seen = 1'b0;
        for (int k = 0; k < cyc_exp + 100 && !seen; k++) begin
            @(negedge CLK);
            // Configuration is latched; later input changes must be ignored.
            ALGORITHM  = 2'($urandom);
            SCALE_LOG2 = 2'($urandom);
            SRC_WIDTH  = XW'($urandom);
            SRC_HEIGHT = YW'($urandom);
            seen = done;
        end
        t1 = cyc_ctr;
        chk("done_seen", longint'(seen), 1);
        if (seen) begin
            chk("job_cycles", longint'(t1 - t0), longint'(cyc_exp));
            chk("error_flag", longint'(error), longint'(err));
            chk("busy_at_done", longint'(busy), 0);
            if (err) chk("err_latency_le2", longint'((t1 - t_en) <= 2), 1);
            chk("reads", longint'(rd_cnt), longint'(nr));
            chk("writes", longint'(wr_cnt), longint'(nw));
            chk("rd_queue_left", longint'(exp_ra.size()), 0);
            chk("wr_queue_left", longint'(exp_wa.size()), 0);
            @(negedge CLK);
            chk("done_held", longint'(done), 1);
            enable = 1'b0;
            @(negedge CLK);
            chk("idle_done", longint'(done), 0);
            chk("idle_error", longint'(error), 0);
            chk("idle_busy", longint'(busy), 0);
        end else begin
            apply_reset();
        end
        exp_ra.delete();
        exp_wa.delete();
        exp_wd.delete();
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) mem[i] = PIX_W'($urandom);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int a, s, w, h;
        RESET = 1'b0; enable = 1'b0;
        ALGORITHM = '0; SCALE_LOG2 = '0; SRC_WIDTH = '0; SRC_HEIGHT = '0;
        #2 RESET = 1'b1;
        #1 chk("reset_outputs",
               longint'({rd_en, wren_out, busy, done, error, R_ADDR, W_ADDR, PIXEL_OUT}), 0);
        #20;
        @(negedge CLK);
        RESET  = 1'b0;
        mon_on = 1'b1;

        // Directed cases
        mem[0] = 8'd10; mem[1] = 8'd20; mem[2] = 8'd30; mem[3] = 8'd40;
        run_job(0, 1, 2, 2);
        mem[0] = 8'd10; mem[1] = 8'd11; mem[2] = 8'd12; mem[3] = 8'd13;
        run_job(3, 1, 2, 2);
        mem[0] = 8'd77;
        run_job(1, 2, 1, 1);
        for (int i = 0; i < 8; i++) mem[i] = PIX_W'(i);
        run_job(2, 1, 4, 2);

        // Rejected jobs
        run_job(0, 3, 2, 2);
        run_job(1, 1, 0, 2);
        run_job(2, 2, 3, 3);
        run_job(0, 2, 2047, 1023);

        // Randomized jobs, all modes and scales
        for (int j = 0; j < 14; j++) begin
            a = $urandom_range(0, 3);
            s = $urandom_range(0, 2);
            w = $urandom_range(1, 6);
            h = $urandom_range(1, 5);
            if (a >= 2 && s > 0 && j < 10) begin
                w = w * (1 << s);
                h = ((h + 1) / 2) * (1 << s);
            end
            fill_rand(w * h);
            run_job(a, s, w, h);
        end

        // Reset in the middle of a block-average accumulation
        fill_rand(16);
        mon_on = 1'b0;
        @(negedge CLK);
        ALGORITHM = 2'b11; SCALE_LOG2 = 2'd2; SRC_WIDTH = XW'(4); SRC_HEIGHT = YW'(4);
        enable = 1'b1;
        repeat (12) @(negedge CLK);
        chk("busy_before_reset", longint'(busy), 1);
        RESET  = 1'b1;
        enable = 1'b0;
        #1 chk("midjob_reset_outputs",
               longint'({rd_en, wren_out, busy, done, error, R_ADDR, W_ADDR, PIXEL_OUT}), 0);
        repeat (2) @(negedge CLK);
        RESET  = 1'b0;
        mon_on = 1'b1;
        run_job(3, 2, 4, 4);
        run_job(3, 1, 4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
